// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that shares one external combinational ALU among NREQ requesters.
// One operation in flight; the answer and flags are registered and returned on a tagged response.
module alu_rr_sched #(
   parameter int NREQ = 2,
   parameter int W    = 16,
   parameter int IDW  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_x,
   input  logic [W*NREQ-1:0] req_y,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_data,
   output logic [2:0]        rsp_flags,
   output logic              rsp_err,
   output logic [W-1:0]      alu_x,
   output logic [W-1:0]      alu_y,
   output logic [3:0]        alu_sel,
   input  logic [W-1:0]      alu_ans,
   input  logic              alu_zero,
   input  logic              alu_neg,
   input  logic              alu_ovf,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_e;

   state_e          state_q;
   logic [IDW-1:0]  rr_q;
   logic [IDW-1:0]  tag_q;
   logic            rsp_valid_q;
   logic [IDW-1:0]  rsp_id_q;
   logic [W-1:0]    rsp_data_q;
   logic [2:0]      rsp_flags_q;
   logic            rsp_err_q;
   logic [W-1:0]    alu_x_q;
   logic [W-1:0]    alu_y_q;
   logic [3:0]      alu_sel_q;

   logic [NREQ-1:0] gnt_d;
   logic [IDW-1:0]  gnt_id_d;
   logic            gnt_any_d;
   logic [IDW-1:0]  rr_d;
   logic [3:0]      sel_op;
   logic [W-1:0]    sel_x;
   logic [W-1:0]    sel_y;
   logic            xfer;

   // First valid requester at or after rr_q, wrapping around.
   always_comb begin
      int idx;
      gnt_d     = '0;
      gnt_id_d  = '0;
      gnt_any_d = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!gnt_any_d && req_valid[idx]) begin
            gnt_any_d  = 1'b1;
            gnt_d[idx] = 1'b1;
            gnt_id_d   = IDW'(idx);
         end
      end
   end

   assign req_ready = (rst_n && state_q == IDLE) ? gnt_d : '0;
   assign xfer      = rst_n && (state_q == IDLE) && gnt_any_d;
   assign sel_op    = req_op[4*int'(gnt_id_d) +: 4];
   assign sel_x     = req_x[W*int'(gnt_id_d) +: W];
   assign sel_y     = req_y[W*int'(gnt_id_d) +: W];
   assign rr_d      = (int'(gnt_id_d) == NREQ-1) ? '0 : gnt_id_d + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         tag_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b0;
         alu_x_q     <= '0;
         alu_y_q     <= '0;
         alu_sel_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  tag_q <= gnt_id_d;
                  rr_q  <= rr_d;
                  // Illegal ops bypass the ALU entirely and leave its operands untouched.
                  if (sel_op[3]) begin
                     rsp_id_q    <= gnt_id_d;
                     rsp_data_q  <= '0;
                     rsp_flags_q <= '0;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end else begin
                     alu_x_q   <= sel_x;
                     alu_y_q   <= sel_y;
                     alu_sel_q <= sel_op;
                     state_q   <= ISSUE;
                  end
               end
            end
            ISSUE: state_q <= CAPT;
            CAPT: begin
               rsp_data_q  <= alu_ans;
               rsp_flags_q <= {alu_ovf, alu_neg, alu_zero};
               rsp_err_q   <= 1'b0;
               rsp_id_q    <= tag_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = rsp_flags_q;
   assign rsp_err   = rsp_err_q;
   assign alu_x     = alu_x_q;
   assign alu_y     = alu_y_q;
   assign alu_sel   = alu_sel_q;
   assign busy      = (state_q != IDLE);

endmodule
